mac3_stream: RTL and testbench

Streaming three-operand arithmetic unit for the exercise datapath. It generalises the fixed 32-bit a*b+c sequence detector with parametrised operand and result widths, a selectable operation, optional saturation with an overflow flag, a configurable output pipeline depth, and a synchronous flush. It consumes one word per clk on a valid-qualified input. It emits one result for every valid word that completes a run of at least three consecutive valid words, using a sliding window.

---
 rtl/mac3_stream.sv | 136 +++++++++++++
 tb/tb_mac3_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac3_stream.sv
// Streaming three-operand arithmetic unit: a sliding window of valid words feeds
// a*b+c / a+b+c / a*b-c / a*b into a LAT-deep pipeline with optional saturation.
module mac3_stream #(
  parameter int unsigned W     = 32,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned LAT   = 1,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             validi,
  input  logic [W-1:0]     data_in,
  input  logic [1:0]       mode,
  output logic             valido,
  output logic [OUT_W-1:0] data_out,
  output logic             ovf
);

  localparam int unsigned XW = 2*W + 1;

  typedef enum logic [1:0] {FILL0, FILL1, RUN} state_t;

  state_t         state;
  logic [W-1:0]   a, b;
  logic           launch;
  logic [XW-1:0]  ea, eb, ec, prod, exact;
  logic           fin_v;
  logic [XW-1:0]  fin_x;
  logic           neg, hi;
  logic [OUT_W-1:0] res_d;

  assign launch = (state == RUN) && validi && !clr;

  // Exact result in XW bits; mode 2 underflow shows up as a set MSB.
  always_comb begin
    ea    = XW'(a);
    eb    = XW'(b);
    ec    = XW'(data_in);
    prod  = ea * eb;
    exact = prod;
    case (mode)
      2'd0:    exact = prod + ec;
      2'd1:    exact = ea + eb + ec;
      2'd2:    exact = prod - ec;
      default: exact = prod;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL0;
      a     <= '0;
      b     <= '0;
    end else if (clr) begin
      state <= FILL0;
    end else begin
      case (state)
        FILL0: if (validi) begin
          a     <= data_in;
          state <= FILL1;
        end
        FILL1: if (validi) begin
          b     <= data_in;
          state <= RUN;
        end else begin
          state <= FILL0;
        end
        RUN: if (validi) begin
          a <= b;
          b <= data_in;
        end else begin
          state <= FILL0;
        end
        default: state <= FILL0;
      endcase
    end
  end

  // LAT-1 carry stages between launch and the output register.
  generate
    if (LAT == 1) begin : g_direct
      assign fin_v = launch;
      assign fin_x = exact;
    end else begin : g_pipe
      logic          sv [LAT-1];
      logic [XW-1:0] sx [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < LAT-1; i++) begin
            sv[i] <= 1'b0;
            sx[i] <= '0;
          end
        end else if (clr) begin
          for (int unsigned i = 0; i < LAT-1; i++) sv[i] <= 1'b0;
        end else begin
          sv[0] <= launch;
          sx[0] <= exact;
          for (int unsigned i = 1; i < LAT-1; i++) begin
            sv[i] <= sv[i-1];
            sx[i] <= sx[i-1];
          end
        end
      end

      assign fin_v = sv[LAT-2];
      assign fin_x = sx[LAT-2];
    end
  endgenerate

  always_comb begin
    neg = fin_x[XW-1];
    hi  = |(fin_x >> OUT_W);
    if (SAT && neg)     res_d = '0;
    else if (SAT && hi) res_d = '1;
    else                res_d = fin_x[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valido   <= 1'b0;
      data_out <= '0;
      ovf      <= 1'b0;
    end else if (clr) begin
      valido <= 1'b0;
    end else begin
      valido <= fin_v;
      if (fin_v) begin
        data_out <= res_d;
        ovf      <= neg | hi;
      end
    end
  end

endmodule

// File: tb/tb_mac3_stream.sv
// Bench for mac3_stream: four parameterisations share one input stream and are
// checked each cycle against a launch-table reference model.
module tb_mac3_stream;

  localparam int NI   = 4;
  localparam int MAXC = 4096;

  int lat [NI] = '{1, 1, 3, 2};
  int iw  [NI] = '{32, 8, 8, 16};
  int iow [NI] = '{32, 8, 8, 33};
  bit isat[NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        validi = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0]  mode = '0;

  logic        vo0, vo1, vo2, vo3;
  logic        ov0, ov1, ov2, ov3;
  logic [31:0] do0;
  logic [7:0]  do1, do2;
  logic [32:0] do3;

  mac3_stream #(.W(32), .OUT_W(32), .LAT(1), .SAT(1'b0)) d0 (
    .clk(clk), .rst(rst), .clr(clr), .validi(validi), .data_in(data_in),
    .mode(mode), .valido(vo0), .data_out(do0), .ovf(ov0));
  mac3_stream #(.W(8), .OUT_W(8), .LAT(1), .SAT(1'b1)) d1 (
    .clk(clk), .rst(rst), .clr(clr), .validi(validi), .data_in(data_in[7:0]),
    .mode(mode), .valido(vo1), .data_out(do1), .ovf(ov1));
  mac3_stream #(.W(8), .OUT_W(8), .LAT(3), .SAT(1'b0)) d2 (
    .clk(clk), .rst(rst), .clr(clr), .validi(validi), .data_in(data_in[7:0]),
    .mode(mode), .valido(vo2), .data_out(do2), .ovf(ov2));
  mac3_stream #(.W(16), .OUT_W(33), .LAT(2), .SAT(1'b0)) d3 (
    .clk(clk), .rst(rst), .clr(clr), .validi(validi), .data_in(data_in[15:0]),
    .mode(mode), .valido(vo3), .data_out(do3), .ovf(ov3));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          launched [MAXC];
  logic [31:0] la [MAXC];
  logic [31:0] lb [MAXC];
  logic [31:0] lc [MAXC];
  logic [1:0]  lm [MAXC];
  bit          killed [NI][MAXC];
  logic [67:0] exp_dout [NI];
  int          run_len = 0;
  logic [31:0] w_old = '0, w_new = '0;
  int          n_pass = 0, n_tot = 0;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Result straight from the arithmetic rules: {ovf, data}.
  function automatic logic [68:0] ref_res(input logic [31:0] a, b, c, input logic [1:0] m,
                                          input int w, input int ow, input bit sat);
    logic [31:0] mask;
    logic signed [67:0] sa, sb, sc, x, mx;
    logic [67:0] d;
    logic o;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sa = $signed({36'd0, a & mask});
    sb = $signed({36'd0, b & mask});
    sc = $signed({36'd0, c & mask});
    case (m)
      2'd0:    x = sa * sb + sc;
      2'd1:    x = sa + sb + sc;
      2'd2:    x = sa * sb - sc;
      default: x = sa * sb;
    endcase
    mx = (68'sd1 <<< ow) - 68'sd1;
    if (x < 0) begin
      o = 1'b1;
      d = sat ? 68'd0 : 68'(x & mx);
    end else if (x > mx) begin
      o = 1'b1;
      d = sat ? 68'(mx) : 68'(x & mx);
    end else begin
      o = 1'b0;
      d = 68'(x);
    end
    return {o, d};
  endfunction

  function automatic logic vo_of(input int i);
    case (i)
      0: return vo0;
      1: return vo1;
      2: return vo2;
      default: return vo3;
    endcase
  endfunction

  function automatic logic ov_of(input int i);
    case (i)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic [67:0] do_of(input int i);
    case (i)
      0: return 68'(do0);
      1: return 68'(do1);
      2: return 68'(do2);
      default: return 68'(do3);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int n;
      bit ev;
      logic [68:0] r;
      n  = int'(cyc) - lat[i] + 1;
      ev = (n >= 1) && (n < MAXC) && launched[n] && !killed[i][n];
      check($sformatf("valido%0d", i), 68'(vo_of(i)), 68'(ev));
      if (ev) begin
        r = ref_res(la[n], lb[n], lc[n], lm[n], iw[i], iow[i], isat[i]);
        exp_dout[i] = r[67:0];
        check($sformatf("data_out%0d", i), do_of(i), r[67:0]);
        check($sformatf("ovf%0d", i), 68'(ov_of(i)), 68'(r[68]));
      end else begin
        check($sformatf("hold%0d", i), do_of(i), exp_dout[i]);
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input logic [1:0] m,
                      input bit c, input bit r);
    int e;
    @(negedge clk);
    check_all();
    rst = r; clr = c; validi = v; data_in = d; mode = m;
    e = int'(cyc) + 1;
    if (r || c) begin
      run_len = 0;
      for (int i = 0; i < NI; i++)
        for (int k = e - lat[i] + 1; k <= e; k++)
          if (k >= 0 && k < MAXC) killed[i][k] = 1'b1;
      if (r) for (int i = 0; i < NI; i++) exp_dout[i] = '0;
    end else if (v) begin
      if (run_len >= 2 && e < MAXC) begin
        launched[e] = 1'b1;
        la[e] = w_old; lb[e] = w_new; lc[e] = d; lm[e] = m;
      end
      w_old = w_new;
      w_new = d;
      run_len++;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) exp_dout[i] = '0;
    step(1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    idle(2);

    for (int k = 2; k <= 5; k++) step(1'b1, 32'(k), 2'd0, 1'b0, 1'b0);
    idle(3);
    check("tp_seq17", 68'(do0), 68'd17);

    step(1'b1, 32'd2, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'd3, 2'd0, 1'b0, 1'b0);
    idle(1);
    for (int k = 4; k <= 6; k++) step(1'b1, 32'(k), 2'd0, 1'b0, 1'b0);
    idle(3);
    check("tp_gap26", 68'(do0), 68'd26);

    step(1'b1, 32'd20, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'd20, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'd10, 2'd0, 1'b0, 1'b0);
    idle(4);
    check("tp_sat255", 68'(do1), 68'd255);
    check("tp_wrap154", 68'(do2), 68'd154);

    step(1'b1, 32'd1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 32'd1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 32'd5, 2'd2, 1'b0, 1'b0);
    idle(4);
    check("tp_neg252", 68'(do2), 68'd252);

    for (int k = 0; k < 3; k++) step(1'b1, 32'd100, 2'd1, 1'b0, 1'b0);
    idle(4);
    check("tp_add44", 68'(do2), 68'd44);

    for (int k = 1; k <= 6; k++) step(1'b1, 32'(k), 2'((k - 1) % 2), 1'b0, 1'b0);
    idle(4);
    check("tp_toggle15", 68'(do2), 68'd15);

    for (int k = 1; k <= 3; k++) step(1'b1, 32'(k), 2'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    idle(2);
    check("tp_rst0", 68'(do2), 68'd0);
    for (int k = 7; k <= 9; k++) step(1'b1, 32'(k), 2'd0, 1'b0, 1'b0);
    idle(4);
    check("tp_rst65", 68'(do2), 68'd65);

    for (int k = 1; k <= 3; k++) step(1'b1, 32'(k), 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'd4, 2'd0, 1'b1, 1'b0);
    idle(4);
    check("tp_clr_hold", 68'(do2), 68'd65);
    for (int k = 7; k <= 9; k++) step(1'b1, 32'(k), 2'd1, 1'b0, 1'b0);
    idle(4);

    for (int t = 0; t < 2000; t++) begin
      bit v, c, r;
      logic [31:0] d;
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) < 2);
      d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      step(v, d, 2'($urandom_range(0, 3)), c, r);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
